// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Pipeline writeback register plus a small output-port FIFO that
//            back-pressures the upstream stage when it cannot take a push.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int OUT_DEPTH = 2,
    parameter int W         = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reg_write_m,
    input  logic         clear_instruction_m,
    input  logic [1:0]   wb_sel_m,
    input  logic [W-1:0] alu_result_m,
    input  logic [W-1:0] mem_data_m,
    input  logic [W-1:0] inport_value,
    input  logic [2:0]   reg_write_address_m,
    input  logic         outport_enable_m,
    input  logic         outport_ready,
    output logic         reg_write_wb,
    output logic [2:0]   reg_write_address_from_wb,
    output logic [W-1:0] reg_write_data_from_wb,
    output logic [W-1:0] outport_data,
    output logic         outport_valid,
    output logic         stall_out,
    output logic [15:0]  retired_count
);

    localparam int c_ptr_w = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(OUT_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(OUT_DEPTH);

    localparam logic [1:0] c_sel_alu = 2'b00;
    localparam logic [1:0] c_sel_mem = 2'b01;
    localparam logic [1:0] c_sel_in  = 2'b10;

    logic [W-1:0]       r_mem [OUT_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               r_reg_write;
    logic [2:0]         r_reg_addr;
    logic [W-1:0]       r_reg_data;
    logic [15:0]        r_retired;

    logic               w_fifo_full;
    logic               w_stall;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [W-1:0]       w_wb_data;

    assign w_fifo_full = (r_count == c_full_count);

    // A pop on the same edge frees the slot, so a full FIFO only stalls
    // when the consumer is not ready.
    assign w_stall  = outport_enable_m && !clear_instruction_m
                      && w_fifo_full && !outport_ready;
    assign w_accept = !clear_instruction_m && !w_stall;
    assign w_push   = outport_enable_m && w_accept;
    assign w_pop    = outport_valid && outport_ready;

    always_comb begin
        w_wb_data = alu_result_m;
        case (wb_sel_m)
            c_sel_alu: w_wb_data = alu_result_m;
            c_sel_mem: w_wb_data = mem_data_m;
            c_sel_in:  w_wb_data = inport_value;
            default:   w_wb_data = alu_result_m;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write <= 1'b0;
            r_reg_addr  <= 3'd0;
            r_reg_data  <= '0;
            r_retired   <= 16'd0;
        end else begin
            r_reg_write <= reg_write_m && w_accept;
            if (w_accept) begin
                r_reg_addr <= reg_write_address_m;
                r_reg_data <= w_wb_data;
                r_retired  <= r_retired + 16'd1;
            end
        end
    end

    // Storage needs no reset: occupancy gates everything that reads it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= alu_result_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign outport_valid             = (r_count != '0);
    assign outport_data              = outport_valid ? r_mem[r_rd_ptr] : '0;
    assign stall_out                 = w_stall;
    assign reg_write_wb              = r_reg_write;
    assign reg_write_address_from_wb = r_reg_addr;
    assign reg_write_data_from_wb    = r_reg_data;
    assign retired_count             = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Scoreboard bench for writeback_stage: driver predicts, monitors
//            compare writeback outputs and output-port traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        reg_write_m;
    logic        clear_instruction_m;
    logic [1:0]  wb_sel_m;
    logic [15:0] alu_result_m;
    logic [15:0] mem_data_m;
    logic [15:0] inport_value;
    logic [2:0]  reg_write_address_m;
    logic        outport_enable_m;
    logic        outport_ready;
    logic        reg_write_wb;
    logic [2:0]  reg_write_address_from_wb;
    logic [15:0] reg_write_data_from_wb;
    logic [15:0] outport_data;
    logic        outport_valid;
    logic        stall_out;
    logic [15:0] retired_count;

    writeback_stage #(.OUT_DEPTH(DEPTH), .W(16)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .reg_write_m               (reg_write_m),
        .clear_instruction_m       (clear_instruction_m),
        .wb_sel_m                  (wb_sel_m),
        .alu_result_m              (alu_result_m),
        .mem_data_m                (mem_data_m),
        .inport_value              (inport_value),
        .reg_write_address_m       (reg_write_address_m),
        .outport_enable_m          (outport_enable_m),
        .outport_ready             (outport_ready),
        .reg_write_wb              (reg_write_wb),
        .reg_write_address_from_wb (reg_write_address_from_wb),
        .reg_write_data_from_wb    (reg_write_data_from_wb),
        .outport_data              (outport_data),
        .outport_valid             (outport_valid),
        .stall_out                 (stall_out),
        .retired_count             (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] cnt;
    } wb_t;

    wb_t         wb_q[$];
    logic [15:0] fifo_model[$];
    int          occ_now;
    bit          cyc_pending;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_cnt;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: stall when the port is wanted, queue holds DEPTH items
    // and nobody is draining; everything not stalled and not a bubble retires.
    task automatic drive(input logic rw, input logic clr, input logic [1:0] sel,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input logic [15:0] inp, input logic [2:0] addr,
                         input logic oe, input logic rdy);
        bit exp_stall;
        bit acc;
        @(negedge clk);
        reg_write_m         = rw;
        clear_instruction_m = clr;
        wb_sel_m            = sel;
        alu_result_m        = alu;
        mem_data_m          = mem;
        inport_value        = inp;
        reg_write_address_m = addr;
        outport_enable_m    = oe;
        outport_ready       = rdy;
        occ_now   = fifo_model.size();
        exp_stall = oe && !clr && (occ_now == DEPTH) && !rdy;
        acc       = !clr && !exp_stall;
        if (acc) begin
            m_addr = addr;
            m_data = (sel == 2'b01) ? mem : (sel == 2'b10) ? inp : alu;
            m_cnt  = m_cnt + 16'd1;
        end
        wb_q.push_back('{we: rw && acc, addr: m_addr, data: m_data, cnt: m_cnt});
        if (oe && acc) fifo_model.push_back(alu);
        cyc_pending = 1'b1;
        #1 check("stall_out", {31'd0, stall_out}, {31'd0, exp_stall});
    endtask

    task automatic drive_rand(input bit allow_bubble, input bit allow_backpressure);
        logic clr;
        logic rdy;
        clr = allow_bubble ? ($urandom_range(0, 3) == 0) : 1'b0;
        rdy = allow_backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
        drive(1'($urandom_range(0, 1)), clr, 2'($urandom_range(0, 3)),
              16'($urandom()), 16'($urandom()), 16'($urandom()),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rdy);
    endtask

    task automatic set_idle();
        reg_write_m         = 1'b0;
        clear_instruction_m = 1'b1;
        wb_sel_m            = 2'b00;
        alu_result_m        = 16'd0;
        mem_data_m          = 16'd0;
        inport_value        = 16'd0;
        reg_write_address_m = 3'd0;
        outport_enable_m    = 1'b0;
        outport_ready       = 1'b0;
    endtask

    task automatic clear_model();
        fifo_model.delete();
        occ_now = 0;
        m_addr  = 3'd0;
        m_data  = 16'd0;
        m_cnt   = 16'd0;
    endtask

    // Writeback monitor: one expectation per driven cycle, visible after the edge.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check("reg_write_wb", {31'd0, reg_write_wb}, {31'd0, e.we});
                check("wb_addr", {29'd0, reg_write_address_from_wb}, {29'd0, e.addr});
                check("wb_data", {16'd0, reg_write_data_from_wb}, {16'd0, e.data});
                check("retired_count", {16'd0, retired_count}, {16'd0, e.cnt});
            end
        end
    end

    // Output-port monitor: samples just before the edge, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (cyc_pending) begin
                cyc_pending = 1'b0;
                check("outport_valid", {31'd0, outport_valid}, {31'd0, occ_now > 0});
                if (occ_now > 0 && outport_ready) begin
                    check("outport_data", {16'd0, outport_data}, {16'd0, fifo_model[0]});
                    void'(fifo_model.pop_front());
                end
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        cyc_pending = 1'b0;
        clear_model();
        set_idle();
        reset = 1'b1;
        #3;
        check("rst_reg_write_wb", {31'd0, reg_write_wb}, 32'd0);
        check("rst_wb_addr", {29'd0, reg_write_address_from_wb}, 32'd0);
        check("rst_wb_data", {16'd0, reg_write_data_from_wb}, 32'd0);
        check("rst_outport_valid", {31'd0, outport_valid}, 32'd0);
        check("rst_outport_data", {16'd0, outport_data}, 32'd0);
        check("rst_retired_count", {16'd0, retired_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Memory-sourced write, then a bubble that must not write or retire.
        drive(1'b1, 1'b0, 2'b01, 16'h1111, 16'hBEEF, 16'h2222, 3'd5, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 16'h3333, 16'h4444, 16'h5555, 3'd2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b10, 16'h0000, 16'h0000, 16'hCAFE, 3'd7, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0000, 16'h0000, 3'd1, 1'b0, 1'b0);

        // Three OUT instructions against a blocked consumer; third stalls.
        drive(1'b0, 1'b0, 2'b00, 16'd1, 16'd0, 16'd0, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 16'd2, 16'd0, 16'd0, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 16'd3, 16'd0, 16'd0, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 16'd3, 16'd0, 16'd0, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 16'd3, 16'd0, 16'd0, 3'd3, 1'b1, 1'b1);
        // Full FIFO with a ready consumer: push and pop together, no stall.
        drive(1'b0, 1'b0, 2'b00, 16'd4, 16'd0, 16'd0, 3'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 16'd5, 16'd0, 16'd0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 2'b00, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) drive_rand(1'b1, 1'b1);

        // Fill the FIFO with two entries, then reset between edges.
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 2'b00, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 2'b00, 16'hA0A0, 16'd0, 16'd0, 3'd4, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 16'hB0B0, 16'd0, 16'd0, 3'd6, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, outport_valid}, 32'd1);
        check("pre_rst_reg_write", {31'd0, reg_write_wb}, 32'd1);
        #2;
        reset = 1'b1;
        set_idle();
        #1;
        check("async_rst_valid", {31'd0, outport_valid}, 32'd0);
        check("async_rst_reg_write", {31'd0, reg_write_wb}, 32'd0);
        check("async_rst_retired", {16'd0, retired_count}, 32'd0);
        check("async_rst_stall", {31'd0, stall_out}, 32'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;

        // Drive the retire counter to its wrap point.
        for (int i = 0; i < 65535; i++) drive_rand(1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("retired_at_ffff", {16'd0, retired_count}, 32'h0000FFFF);
        drive_rand(1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("retired_wrap", {16'd0, retired_count}, 32'd0);

        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 2'b00, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("model_fifo_drained", fifo_model.size(), 32'd0);
        check("wb_queue_drained", wb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, meaning number of entries in the output-port FIFO.
REQ-002 SHALL have parameter W, default 16, meaning datapath width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port reg_write_m, input, 1, memory-stage register-write enable.
REQ-006 SHALL have port clear_instruction_m, input, 1, memory-stage bubble flag; 1 nullifies the instruction.
REQ-007 SHALL have port wb_sel_m, input, 2, writeback source select: 00 ALU, 01 memory, 10 in-port, 11 ALU.
REQ-008 SHALL have port alu_result_m, input, W, ALU result.
REQ-009 SHALL have port mem_data_m, input, W, memory read data.
REQ-010 SHALL have port inport_value, input, W, external input-port value.
REQ-011 SHALL have port reg_write_address_m, input, 3, destination register.
REQ-012 SHALL have port outport_enable_m, input, 1, instruction writes the output port.
REQ-013 SHALL have port outport_ready, input, 1, external consumer accepts the FIFO head.
REQ-014 SHALL have port reg_write_wb, output, 1, register-file write enable to decode.
REQ-015 SHALL have port reg_write_address_from_wb, output, 3, register-file write address.
REQ-016 SHALL have port reg_write_data_from_wb, output, W, register-file write data.
REQ-017 SHALL have port outport_data, output, W, FIFO head data.
REQ-018 SHALL have port outport_valid, output, 1, FIFO non-empty.
REQ-019 SHALL have port stall_out, output, 1, upstream must hold its instruction this cycle.
REQ-020 SHALL have port retired_count, output, 16, count of non-bubble instructions accepted.

Function
REQ-021 SHALL define accept = !clear_instruction_m && !stall_out.
REQ-022 SHALL select data combinationally per wb_sel_m; the value of inport_value is sampled in the accept cycle.
REQ-023 SHALL register {reg_write_m && accept, reg_write_address_m, selected data} each edge, giving 1-cycle latency to the reg_write_wb/address/data outputs.
REQ-024 SHALL load reg_write_wb=0 when not accepted, holding the previous address and data.
REQ-025 SHALL push alu_result_m into the FIFO on an edge where outport_enable_m && accept.
REQ-026 SHALL pop the FIFO head on an edge where outport_valid && outport_ready.
REQ-027 SHALL assert stall_out combinationally iff outport_enable_m && !clear_instruction_m && FIFO full && !outport_ready.
REQ-028 SHALL allow a simultaneous push and pop when the FIFO is full (occupancy unchanged, no stall).
REQ-029 SHALL make a push into an empty FIFO visible on outport_valid/outport_data one cycle later, with no combinational bypass.
REQ-030 SHALL use wrapping read/write pointers modulo OUT_DEPTH and an occupancy counter 0..OUT_DEPTH.
REQ-031 SHALL increment retired_count by 1 on each accepted instruction, wrapping from 16'hFFFF to 0.
REQ-032 SHALL make a stalled instruction cause neither a register write nor a push until it is accepted.

Reset
REQ-033 SHALL clear reg_write_wb, the write address, write data, outport_data, outport_valid, the FIFO pointers and occupancy, and retired_count to 0 asynchronously while reset=1.
REQ-034 SHALL discard FIFO contents on reset mid-operation; stall_out follows its combinational definition with an empty FIFO.

Verification
REQ-035 SHALL cover: wb_sel_m=01, mem_data_m=16'hBEEF, addr 5, reg_write_m=1 -> next cycle reg_write_wb=1, addr=5, data=16'hBEEF.
REQ-036 SHALL cover: clear_instruction_m=1 with reg_write_m=1 -> reg_write_wb=0 next cycle and retired_count unchanged.
REQ-037 SHALL cover: outport_ready=0 and three OUT instructions (values 1, 2, 3) -> after two pushes outport_valid=1, data=1; stall_out=1 on the third; raising ready then pops 1, pushes 3, and stall_out=0.
REQ-038 SHALL cover: full FIFO, outport_ready=1, new OUT instruction -> no stall, occupancy stays 2, order preserved.
REQ-039 SHALL cover: retired_count preloaded to 16'hFFFF by 65535 accepts, then one more accept -> 16'h0000.
REQ-040 SHALL cover: reset asserted mid-cycle with FIFO holding 2 entries -> outport_valid=0 and reg_write_wb=0 immediately, without waiting for a clock edge.
